// File: rtl/pll_ce_synth.sv
// Purpose : multi-channel fractional clock-enable synthesiser (phase accumulators) with glitch-free retune.
// Latency : ce_out registered, one cycle after the carry; config applied on the target channel's next carry.
// Backpress: single pending config slot; cfg_ready low from acceptance until the cycle after apply.
//
// Ports:
//   i_refclk, i_rst_n        single clock, synchronous active-low reset
//   i_cfg_valid/o_cfg_ready  config write handshake (i_cfg_ch, i_cfg_inc, i_cfg_phase)
//   i_sync_req               one-cycle pulse: reload every accumulator from its phase register
//   o_ce_out                 per-channel enable pulses
//   o_locked                 all channels settled at programmed settings
//   o_busy                   a config is pending
module pll_ce_synth #(
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 32,
    parameter int LOCK_CYC = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W   = $clog2(LOCK_CYC + 1)
) (
    input  logic              i_refclk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [ACC_W-1:0]  i_cfg_inc,
    input  logic [ACC_W-1:0]  i_cfg_phase,
    input  logic              i_sync_req,
    output logic [NUM_CH-1:0] o_ce_out,
    output logic              o_locked,
    output logic              o_busy
);

    logic [ACC_W-1:0] r_acc   [NUM_CH];
    logic [ACC_W-1:0] r_inc   [NUM_CH];
    logic [ACC_W-1:0] r_phase [NUM_CH];
    logic [NUM_CH-1:0] r_ce;

    logic             r_pend;
    logic [CH_W-1:0]  r_pend_ch;
    logic [ACC_W-1:0] r_pend_inc;
    logic [ACC_W-1:0] r_pend_phase;
    logic [CNT_W-1:0] r_lock_cnt;

    logic [ACC_W:0]    w_sum [NUM_CH];
    logic [NUM_CH-1:0] w_carry;
    logic [NUM_CH-1:0] w_tgt;
    logic              w_apply;
    logic              w_ch_ok;
    logic              w_accept;

    // Channel field may be wider than needed (non power-of-two NUM_CH); out-of-range writes are dropped.
    assign w_ch_ok  = ({1'b0, i_cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign w_accept = i_cfg_valid && !r_pend;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i]   = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
            w_carry[i] = w_sum[i][ACC_W];
        end
    end

    // Apply on the target's carry so the retune lands exactly on a pulse boundary. A stopped
    // channel never carries, so it is retuned immediately; sync_req also forces the apply.
    always_comb begin
        w_apply = r_pend && (w_carry[r_pend_ch] || (r_inc[r_pend_ch] == '0) || i_sync_req);
        for (int i = 0; i < NUM_CH; i++) begin
            w_tgt[i] = w_apply && (r_pend_ch == CH_W'(i));
        end
    end

    always_ff @(posedge i_refclk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]   <= '0;
                r_inc[i]   <= '0;
                r_phase[i] <= '0;
            end
            r_ce         <= '0;
            r_pend       <= 1'b0;
            r_pend_ch    <= '0;
            r_pend_inc   <= '0;
            r_pend_phase <= '0;
            r_lock_cnt   <= CNT_W'(LOCK_CYC);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_tgt[i]) begin
                    r_acc[i]   <= r_pend_phase;
                    r_inc[i]   <= r_pend_inc;
                    r_phase[i] <= r_pend_phase;
                end else if (i_sync_req) begin
                    r_acc[i] <= r_phase[i];
                end else begin
                    r_acc[i] <= w_sum[i][ACC_W-1:0];
                end
            end

            // The apply cycle still emits its pulse; only a sync suppresses carries.
            r_ce <= i_sync_req ? '0 : w_carry;

            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (w_accept && w_ch_ok) begin
                r_pend       <= 1'b1;
                r_pend_ch    <= i_cfg_ch;
                r_pend_inc   <= i_cfg_inc;
                r_pend_phase <= i_cfg_phase;
            end

            if (w_apply) begin
                r_lock_cnt <= CNT_W'(LOCK_CYC);
            end else if (!r_pend && (r_lock_cnt != '0)) begin
                r_lock_cnt <= r_lock_cnt - CNT_W'(1);
            end
        end
    end

    assign o_ce_out    = r_ce;
    assign o_cfg_ready = !r_pend;
    assign o_busy      = r_pend;
    // A pending write holds lock low even if the countdown had already finished.
    assign o_locked    = (r_lock_cnt == '0) && !r_pend;

endmodule
